counter_updn_ld: RTL and testbench

Parametrised up/down counter with an arbitrary count window [LLIMIT, ULIMIT], synchronous load, and a wrap or saturate mode. It provides a combinational terminal-count output for cascading and a registered wrap pulse. It is the general-purpose successor to the plain enable counter and is used for timers, debounce and scan dividers in the switch/display paths.

---
 rtl/counter_updn_ld_pkg.sv | 26 ++
 rtl/counter_defs.vh | 11 +
 rtl/flopr_en.sv | 33 +++
 rtl/counter_updn_ld.sv | 138 +++++++++++++
 tb/tb_counter_updn_ld.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_updn_ld_pkg.sv
// Types shared by counter_updn_ld: next-count source select and the step decode helper.
package counter_updn_ld_pkg;

  typedef enum logic [2:0] {
    SEL_HOLD  = 3'd0,
    SEL_CLEAR = 3'd1,
    SEL_LOAD  = 3'd2,
    SEL_INC   = 3'd3,
    SEL_DEC   = 3'd4,
    SEL_TO_LO = 3'd5,
    SEL_TO_HI = 3'd6
  } cnt_sel_e;

  // The window check comes before any arithmetic, so inc/dec never overflow.
  function automatic cnt_sel_e step_sel(input logic up, input logic at_hi,
                                        input logic at_lo, input logic sat);
    cnt_sel_e sel;
    if (up) begin
      sel = at_hi ? (sat ? SEL_HOLD : SEL_TO_LO) : SEL_INC;
    end else begin
      sel = at_lo ? (sat ? SEL_HOLD : SEL_TO_HI) : SEL_DEC;
    end
    return sel;
  endfunction

endpackage

// File: rtl/counter_defs.vh
// Direction and mode encodings shared by the counter family.
`ifndef COUNTER_DEFS_VH
`define COUNTER_DEFS_VH

`define CNT_DIR_UP    1'b1
`define CNT_DIR_DOWN  1'b0

`define CNT_MODE_WRAP 0
`define CNT_MODE_SAT  1

`endif

// File: rtl/flopr_en.sv
// Enabled register with synchronous clear; one-cycle latency, no backpressure.
module flopr_en #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             i_sclr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (i_en) begin
      q_d = i_d;
    end
  end

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign o_q = q_q;

endmodule

// File: rtl/counter_updn_ld.sv
`include "counter_defs.vh"
// Windowed up/down counter with clamped load, wrap/saturate, cascade tc and wrap pulse.
// o_tc is zero-latency, o_cnt/o_wrap registered; no backpressure. Option: COUNTER_UPDN_LD_PRESCALE_EN.
module counter_updn_ld
  import counter_updn_ld_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] LLIMIT   = '0,
  parameter logic [WIDTH-1:0] ULIMIT   = {WIDTH{1'b1}},
  parameter int               SATURATE = 0,
  parameter int               PRESCALE = 4
) (
  input  logic             clk,
  input  logic             i_sclr,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_ld_val,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_tc,
  output logic             o_wrap
);

  localparam bit SAT_MODE = (SATURATE == `CNT_MODE_SAT);

  logic             step;
  logic             at_hi;
  logic             at_lo;
  logic             at_limit;
  logic             tc;
  logic             cnt_en;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] ld_clamped;
  cnt_sel_e         sel;
  logic             wrap_d;
  logic             wrap_q;

  // A misconfigured window or prescale shows up as this block in the elaborated hierarchy.
  if (WIDTH < 2 || LLIMIT >= ULIMIT || PRESCALE < 2) begin : g_bad_params
  end

`ifdef COUNTER_UPDN_LD_PRESCALE_EN
  localparam int              PS_W    = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] ps_q;
  logic [PS_W-1:0] ps_d;

  always_comb begin
    ps_d = ps_q;
    if (i_load) begin
      ps_d = '0;
    end else if (i_en) begin
      ps_d = (ps_q == PS_LAST) ? '0 : ps_q + PS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end

  assign step = i_en & (ps_q == PS_LAST);
`else
  assign step = i_en;
`endif

  assign at_hi    = (cnt_q == ULIMIT);
  assign at_lo    = (cnt_q == LLIMIT);
  assign at_limit = (i_up == `CNT_DIR_UP) ? at_hi : at_lo;
  assign tc       = step & ~i_sclr & ~i_load & at_limit;

  always_comb begin
    ld_clamped = i_ld_val;
    if (i_ld_val >= ULIMIT) begin
      ld_clamped = ULIMIT;
    end else if (i_ld_val <= LLIMIT) begin
      ld_clamped = LLIMIT;
    end
  end

  always_comb begin
    sel = SEL_HOLD;
    if (i_sclr) begin
      sel = SEL_CLEAR;
    end else if (i_load) begin
      sel = SEL_LOAD;
    end else if (step) begin
      sel = step_sel(i_up, at_hi, at_lo, SAT_MODE);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case (sel)
      SEL_CLEAR: cnt_d = LLIMIT;
      SEL_LOAD:  cnt_d = ld_clamped;
      SEL_INC:   cnt_d = cnt_q + WIDTH'(1);
      SEL_DEC:   cnt_d = cnt_q - WIDTH'(1);
      SEL_TO_LO: cnt_d = LLIMIT;
      SEL_TO_HI: cnt_d = ULIMIT;
      default:   cnt_d = cnt_q;
    endcase
  end

  assign cnt_en = i_sclr | i_load | step;

  flopr_en #(
    .WIDTH  (WIDTH),
    .RST_VAL(LLIMIT)
  ) u_cnt_reg (
    .clk   (clk),
    .i_sclr(1'b0),
    .i_en  (cnt_en),
    .i_d   (cnt_d),
    .o_q   (cnt_q)
  );

  // A limit hit with a step is a wrap unless the counter saturates there.
  assign wrap_d = tc & ~SAT_MODE;

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign o_cnt  = cnt_q;
  assign o_tc   = tc;
  assign o_wrap = wrap_q;

endmodule

// File: tb/tb_counter_updn_ld.sv
// Bench for counter_updn_ld: window [3,12], one wrap-mode and one saturate-mode instance.
module tb_counter_updn_ld;

  typedef struct packed {
    logic       sclr;
    logic       load;
    logic       en;
    logic       up;
    logic [3:0] ldv;
  } stim_t;

  typedef struct packed {
    logic [3:0] cnt;
    logic       wrap;
    logic       tc;
  } exp_t;

`ifdef COUNTER_UPDN_LD_PRESCALE_EN
  localparam bit PS_EN = 1'b1;
`else
  localparam bit PS_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       w_sclr = 1'b0, w_load = 1'b0, w_en = 1'b0, w_up = 1'b0;
  logic [3:0] w_ldv = 4'd0;
  logic [3:0] w_cnt;
  logic       w_tc, w_wrap;
  logic       s_sclr = 1'b0, s_load = 1'b0, s_en = 1'b0, s_up = 1'b0;
  logic [3:0] s_ldv = 4'd0;
  logic [3:0] s_cnt;
  logic       s_tc, s_wrap;

  exp_t       q_w[$];
  exp_t       q_s[$];
  logic [3:0] mw_cnt = 4'd3;
  logic [3:0] ms_cnt = 4'd3;
  int         mw_ps = 0;
  int         ms_ps = 0;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  counter_updn_ld #(.WIDTH(4), .LLIMIT(4'd3), .ULIMIT(4'd12), .SATURATE(0), .PRESCALE(4)) dut_w (
    .clk(clk), .i_sclr(w_sclr), .i_en(w_en), .i_up(w_up), .i_load(w_load), .i_ld_val(w_ldv),
    .o_cnt(w_cnt), .o_tc(w_tc), .o_wrap(w_wrap)
  );

  counter_updn_ld #(.WIDTH(4), .LLIMIT(4'd3), .ULIMIT(4'd12), .SATURATE(1), .PRESCALE(4)) dut_s (
    .clk(clk), .i_sclr(s_sclr), .i_en(s_en), .i_up(s_up), .i_load(s_load), .i_ld_val(s_ldv),
    .o_cnt(s_cnt), .o_tc(s_tc), .o_wrap(s_wrap)
  );

  function automatic stim_t mk(input logic sclr, input logic load, input logic en,
                               input logic up, input logic [3:0] ldv);
    stim_t s;
    s.sclr = sclr; s.load = load; s.en = en; s.up = up; s.ldv = ldv;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.sclr = ($urandom_range(0, 31) == 0);
    s.load = ($urandom_range(0, 7) == 0);
    s.en   = ($urandom_range(0, 3) != 0);
    s.up   = ($urandom_range(0, 1) == 1);
    s.ldv  = 4'($urandom_range(0, 15));
    return s;
  endfunction

  // Reference behaviour of one counter with window [3,12]; returns next state and current tc.
  function automatic exp_t model(input bit sat, input logic [3:0] cnt, input int ps,
                                 input stim_t s, output int ps_n);
    exp_t e;
    logic step;
    step   = s.en && (!PS_EN || ps == 3);
    e.tc   = step && !s.sclr && !s.load && (s.up ? (cnt == 4'd12) : (cnt == 4'd3));
    e.wrap = 1'b0;
    e.cnt  = cnt;
    ps_n   = ps;
    if (s.sclr) begin
      e.cnt = 4'd3; ps_n = 0;
    end else if (s.load) begin
      e.cnt = (s.ldv > 4'd12) ? 4'd12 : ((s.ldv < 4'd3) ? 4'd3 : s.ldv);
      ps_n  = 0;
    end else begin
      if (s.en) ps_n = (ps == 3) ? 0 : ps + 1;
      if (step && s.up) begin
        if (cnt < 4'd12) e.cnt = cnt + 4'd1;
        else if (!sat) begin e.cnt = 4'd3; e.wrap = 1'b1; end
      end else if (step) begin
        if (cnt > 4'd3) e.cnt = cnt - 4'd1;
        else if (!sat) begin e.cnt = 4'd12; e.wrap = 1'b1; end
      end
    end
    return e;
  endfunction

  task automatic drive(input bit sat, input stim_t s);
    exp_t e;
    int   psn;
    if (!sat) begin
      {w_sclr, w_load, w_en, w_up, w_ldv} = s;
      e = model(1'b0, mw_cnt, mw_ps, s, psn);
      mw_cnt = e.cnt; mw_ps = psn;
      q_w.push_back(e);
    end else begin
      {s_sclr, s_load, s_en, s_up, s_ldv} = s;
      e = model(1'b1, ms_cnt, ms_ps, s, psn);
      ms_cnt = e.cnt; ms_ps = psn;
      q_s.push_back(e);
    end
  endtask

  task automatic idle_all();
    {w_sclr, w_load, w_en, w_up, w_ldv} = '0;
    {s_sclr, s_load, s_en, s_up, s_ldv} = '0;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1'b0, mk(1, 1, 1, 1, 4'd9));
      drive(1'b1, mk(1, 1, 1, 1, 4'd9));
      #1;
      tests++;
      if (w_tc !== 1'b0 || s_tc !== 1'b0) begin
        fails++; $display("FAIL reset_tc: got %b/%b want 0/0", w_tc, s_tc);
      end
      @(posedge clk); #1;
      e = q_w.pop_front();
      tests++;
      if (w_cnt !== e.cnt || w_wrap !== e.wrap) begin
        fails++; $display("FAIL reset_w: got %0d/%b want %0d/%b", w_cnt, w_wrap, e.cnt, e.wrap);
      end
      e = q_s.pop_front();
      tests++;
      if (s_cnt !== e.cnt || s_wrap !== e.wrap) begin
        fails++; $display("FAIL reset_s: got %0d/%b want %0d/%b", s_cnt, s_wrap, e.cnt, e.wrap);
      end
    end
    tests++;
    if (w_cnt !== 4'd3 || w_wrap !== 1'b0 || s_cnt !== 4'd3 || s_wrap !== 1'b0) begin
      fails++; $display("FAIL reset_state: got %0d/%b %0d/%b want 3/0 3/0", w_cnt, w_wrap, s_cnt, s_wrap);
    end
    idle_all();
  endtask

  task automatic test_up_wrap();
    exp_t e;
    int   tc_hi = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(1'b0, mk(0, 0, (i < 10), 1, 4'd0));
      #1;
      tests++;
      if (w_tc !== q_w[0].tc) begin
        fails++; $display("FAIL up_wrap_tc cyc %0d: got %b want %b", i, w_tc, q_w[0].tc);
      end
      if (w_tc === 1'b1) tc_hi++;
      @(posedge clk); #1;
      e = q_w.pop_front();
      tests++;
      if (w_cnt !== e.cnt || w_wrap !== e.wrap) begin
        fails++; $display("FAIL up_wrap cyc %0d: got %0d/%b want %0d/%b", i, w_cnt, w_wrap, e.cnt, e.wrap);
      end
      if (i == 9) begin
        tests++;
        if (w_cnt !== 4'd3 || w_wrap !== 1'b1) begin
          fails++; $display("FAIL up_wrap_edge: got %0d/%b want 3/1", w_cnt, w_wrap);
        end
      end
    end
    tests++;
    if (tc_hi !== 1 || w_wrap !== 1'b0) begin
      fails++; $display("FAIL up_wrap_pulse: tc_hi %0d wrap %b want 1 and 0", tc_hi, w_wrap);
    end
    idle_all();
  endtask

  task automatic test_down_wrap();
    exp_t  e;
    stim_t s;
    for (int i = 0; i < 8; i++) begin
      if (i == 0)      s = mk(0, 1, 0, 0, 4'd4);
      else if (i == 7) s = mk(0, 0, 1, 1, 4'd0);
      else             s = mk(0, 0, 1, 0, 4'd0);
      @(negedge clk);
      drive(1'b0, s);
      #1;
      tests++;
      if (w_tc !== q_w[0].tc || (i == 2 && w_tc !== 1'b1)) begin
        fails++; $display("FAIL down_wrap_tc cyc %0d: got %b want %b", i, w_tc, q_w[0].tc);
      end
      @(posedge clk); #1;
      e = q_w.pop_front();
      tests++;
      if (w_cnt !== e.cnt || w_wrap !== e.wrap) begin
        fails++; $display("FAIL down_wrap cyc %0d: got %0d/%b want %0d/%b", i, w_cnt, w_wrap, e.cnt, e.wrap);
      end
      if (i == 2) begin
        tests++;
        if (w_cnt !== 4'd12 || w_wrap !== 1'b1) begin
          fails++; $display("FAIL down_wrap_edge: got %0d/%b want 12/1", w_cnt, w_wrap);
        end
      end
    end
    tests++;
    if (w_cnt !== 4'd9) begin
      fails++; $display("FAIL down_flip: got %0d want 9", w_cnt);
    end
    idle_all();
  endtask

  task automatic test_load_clamp();
    stim_t      st [0:6];
    logic [3:0] want [0:6];
    exp_t       e;
    st[0] = mk(0, 1, 0, 1, 4'd15); want[0] = 4'd12;
    st[1] = mk(0, 1, 0, 1, 4'd1);  want[1] = 4'd3;
    st[2] = mk(0, 1, 0, 1, 4'd7);  want[2] = 4'd7;
    st[3] = mk(0, 1, 1, 1, 4'd7);  want[3] = 4'd7;
    st[4] = mk(0, 1, 0, 1, 4'd12); want[4] = 4'd12;
    st[5] = mk(0, 1, 1, 1, 4'd3);  want[5] = 4'd3;
    st[6] = mk(1, 1, 1, 1, 4'd9);  want[6] = 4'd3;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(1'b0, st[i]);
      #1;
      tests++;
      if (w_tc !== 1'b0) begin
        fails++; $display("FAIL load_tc cyc %0d: got %b want 0", i, w_tc);
      end
      @(posedge clk); #1;
      e = q_w.pop_front();
      tests++;
      if (w_cnt !== want[i] || w_cnt !== e.cnt || w_wrap !== 1'b0) begin
        fails++; $display("FAIL load_clamp cyc %0d: got %0d/%b want %0d/0", i, w_cnt, w_wrap, want[i]);
      end
    end
    idle_all();
  endtask

  task automatic test_saturate();
    exp_t e;
    int   tc_hi = 0;
    int   wrap_hi = 0;
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      drive(1'b1, mk(0, 0, 1, (i < 14), 4'd0));
      #1;
      tests++;
      if (s_tc !== q_s[0].tc) begin
        fails++; $display("FAIL sat_tc cyc %0d: got %b want %b", i, s_tc, q_s[0].tc);
      end
      if (s_tc === 1'b1) tc_hi++;
      @(posedge clk); #1;
      e = q_s.pop_front();
      if (s_wrap !== 1'b0) wrap_hi++;
      tests++;
      if (s_cnt !== e.cnt || s_wrap !== e.wrap) begin
        fails++; $display("FAIL sat cyc %0d: got %0d/%b want %0d/%b", i, s_cnt, s_wrap, e.cnt, e.wrap);
      end
      if (i == 13 || i == 27) begin
        tests++;
        if (s_cnt !== ((i == 13) ? 4'd12 : 4'd3)) begin
          fails++; $display("FAIL sat_hold cyc %0d: got %0d", i, s_cnt);
        end
      end
    end
    tests++;
    if (tc_hi !== 10 || wrap_hi !== 0) begin
      fails++; $display("FAIL sat_summary: tc_hi %0d wrap_hi %0d want 10 and 0", tc_hi, wrap_hi);
    end
    idle_all();
  endtask

`ifdef COUNTER_UPDN_LD_PRESCALE_EN
  task automatic test_prescale();
    exp_t       e;
    stim_t      s;
    logic [3:0] prev;
    int         changes = 0;
    int         tc_hi = 0;
    for (int i = 0; i < 31; i++) begin
      s = mk((i == 0), (i == 26), !(i == 0 || (i >= 19 && i <= 21)), 1, 4'd12);
      prev = w_cnt;
      @(negedge clk);
      drive(1'b0, s);
      #1;
      tests++;
      if (w_tc !== q_w[0].tc) begin
        fails++; $display("FAIL ps_tc cyc %0d: got %b want %b", i, w_tc, q_w[0].tc);
      end
      if (i >= 27 && w_tc === 1'b1) tc_hi++;
      if (i == 30) begin
        tests++;
        if (w_tc !== 1'b1) begin
          fails++; $display("FAIL ps_tc_4th: got %b want 1", w_tc);
        end
      end
      @(posedge clk); #1;
      e = q_w.pop_front();
      if (i >= 1 && i <= 16 && w_cnt !== prev) changes++;
      tests++;
      if (w_cnt !== e.cnt || w_wrap !== e.wrap) begin
        fails++; $display("FAIL ps cyc %0d: got %0d/%b want %0d/%b", i, w_cnt, w_wrap, e.cnt, e.wrap);
      end
      if (i == 16 || i == 22 || i == 23) begin
        tests++;
        if (w_cnt !== ((i == 23) ? 4'd8 : 4'd7)) begin
          fails++; $display("FAIL ps_period cyc %0d: got %0d", i, w_cnt);
        end
      end
    end
    tests++;
    if (changes !== 4 || tc_hi !== 1 || w_cnt !== 4'd3 || w_wrap !== 1'b1) begin
      fails++; $display("FAIL ps_summary: changes %0d tc_hi %0d cnt %0d wrap %b want 4 1 3 1",
                        changes, tc_hi, w_cnt, w_wrap);
    end
    idle_all();
  endtask
`endif

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      drive(1'b0, rnd());
      drive(1'b1, rnd());
      #1;
      tests++;
      if (w_tc !== q_w[0].tc || s_tc !== q_s[0].tc) begin
        fails++; $display("FAIL b2b_tc cyc %0d: got %b/%b want %b/%b", i, w_tc, s_tc, q_w[0].tc, q_s[0].tc);
      end
      @(posedge clk); #1;
      e = q_w.pop_front();
      tests++;
      if (w_cnt !== e.cnt || w_wrap !== e.wrap) begin
        fails++; $display("FAIL b2b_w cyc %0d: got %0d/%b want %0d/%b", i, w_cnt, w_wrap, e.cnt, e.wrap);
      end
      e = q_s.pop_front();
      tests++;
      if (s_cnt !== e.cnt || s_wrap !== e.wrap) begin
        fails++; $display("FAIL b2b_s cyc %0d: got %0d/%b want %0d/%b", i, s_cnt, s_wrap, e.cnt, e.wrap);
      end
    end
    idle_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
`ifdef COUNTER_UPDN_LD_PRESCALE_EN
    test_load_clamp();
    test_prescale();
`else
    test_up_wrap();
    test_down_wrap();
    test_load_clamp();
    test_saturate();
`endif
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
